// File: rtl/mux_pkg.sv
// mux_pkg: shared constants, mode encodings and the select-width helper for stream_mux_nto1.
package mux_pkg;

   localparam int MIN_CHANNELS = 2;
   localparam int MAX_CHANNELS = 16;

   typedef enum logic {
      MODE_FIXED = 1'b0,
      MODE_RR    = 1'b1
   } mode_e;

   // Ceiling log2 clamped to 1 so a select field never collapses to zero width.
   function automatic int clog2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r++;
      return (r < 1) ? 1 : r;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin search starting one past the last granted channel.
module rr_arbiter
   import mux_pkg::*;
#(
   parameter  int NChannels = 4,
   localparam int SelBits   = clog2(NChannels)
) (
   input  logic [NChannels-1:0] req,
   input  logic [SelBits-1:0]   ptr,
   output logic [SelBits-1:0]   grant,
   output logic                 grant_valid
);

   int                 idx;
   logic [SelBits-1:0] idx_s;

   always_comb begin
      grant       = '0;
      grant_valid = 1'b0;
      idx         = 0;
      idx_s       = '0;
      // Offsets 1..NChannels visit every channel once, ending on the pointer itself.
      for (int i = 1; i <= NChannels; i++) begin
         idx   = (int'(ptr) + i) % NChannels;
         idx_s = SelBits'(idx);
         if (!grant_valid && req[idx_s]) begin
            grant       = idx_s;
            grant_valid = 1'b1;
         end
      end
   end

endmodule

// File: rtl/stream_mux_nto1.sv
// stream_mux_nto1: N-to-1 stream multiplexer with one registered output stage.
// Defining STREAM_MUX_ROUND_ROBIN_EN adds the Mode port and round-robin arbitration.
module stream_mux_nto1
   import mux_pkg::*;
#(
   parameter  int NBits     = 32,
   parameter  int NChannels = 4,
   localparam int SelBits   = clog2(NChannels)
) (
   input  logic                       clk,
   input  logic                       reset,
`ifdef STREAM_MUX_ROUND_ROBIN_EN
   input  logic                       Mode,
`endif
   input  logic [SelBits-1:0]         Selector,
   input  logic [NChannels*NBits-1:0] In_Data,
   input  logic [NChannels-1:0]       In_Valid,
   output logic [NChannels-1:0]       In_Ready,
   output logic [NBits-1:0]           Out_Data,
   output logic                       Out_Valid,
   input  logic                       Out_Ready,
   output logic [SelBits-1:0]         Out_Channel
);

   logic               can_accept;
   logic [SelBits-1:0] fixed_grant;
   logic [SelBits-1:0] grant;
   logic               grant_ok;
   logic               xfer;

   assign can_accept  = !Out_Valid || Out_Ready;
   assign fixed_grant = (int'(Selector) < NChannels) ? Selector : '0;

`ifdef STREAM_MUX_ROUND_ROBIN_EN
   logic [SelBits-1:0] rr_ptr;
   logic [SelBits-1:0] rr_grant;
   logic               rr_valid;

   rr_arbiter #(
      .NChannels (NChannels)
   ) u_rr_arbiter (
      .req         (In_Valid),
      .ptr         (rr_ptr),
      .grant       (rr_grant),
      .grant_valid (rr_valid)
   );

   assign grant    = (Mode == MODE_RR) ? rr_grant : fixed_grant;
   assign grant_ok = (Mode == MODE_RR) ? rr_valid : 1'b1;

   // Pointer tracks the last channel that actually transferred, in either mode.
   always_ff @(posedge clk) begin
      if (reset)     rr_ptr <= SelBits'(NChannels - 1);
      else if (xfer) rr_ptr <= grant;
   end
`else
   assign grant    = fixed_grant;
   assign grant_ok = 1'b1;
`endif

   always_comb begin
      // NOTE: default assignment first so every path drives In_Ready and no latch is inferred.
      In_Ready = '0;
      if (!reset && grant_ok && can_accept) In_Ready[grant] = 1'b1;
   end

   assign xfer = |(In_Valid & In_Ready);

   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      if (reset) begin
         Out_Valid   <= 1'b0;
         Out_Data    <= '0;
         Out_Channel <= '0;
      end else if (xfer) begin
         Out_Valid   <= 1'b1;
         Out_Data    <= In_Data[int'(grant)*NBits +: NBits];
         Out_Channel <= grant;
      end else if (Out_Ready) begin
         Out_Valid   <= 1'b0;
      end
   end

endmodule
